// File: rtl/player_shooter.sv
// Player-side projectile launcher: synchronised keys drive a 16-sector aim angle and a
// one-cycle shot pulse, gated by per-type cooldown and a kill-recharged ultimate.
module player_shooter #(
    parameter int unsigned COOLDOWN_T1      = 12500000,
    parameter int unsigned COOLDOWN_T2      = 25000000,
    parameter int unsigned COOLDOWN_T3      = 50000000,
    parameter int unsigned ULT_MAX          = 2,
    parameter int unsigned KILLS_PER_CHARGE = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_fire,
    input  logic [1:0]  shootingtype,
    input  logic        over,
    input  logic [15:0] kill_count,
    output logic [3:0]  hit_angle,
    output logic        outgoing_projectiles,
    output logic [1:0]  shot_type,
    output logic [1:0]  ult_charges,
    output logic        ready
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FIRE     = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;
    localparam int CW = $clog2(KILLS_PER_CHARGE + 1);

    logic [2:0] btn_raw;
    logic [2:0] edge_det;
    logic       edge_left, edge_right, edge_fire;

    assign btn_raw    = {btn_fire, btn_right, btn_left};
    assign edge_left  = edge_det[0];
    assign edge_right = edge_det[1];
    assign edge_fire  = edge_det[2];

    // Flops preload to 1 in reset so a key held through reset never produces an edge.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg, s2_reg, hist_reg;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    s1_reg   <= 1'b1;
                    s2_reg   <= 1'b1;
                    hist_reg <= 1'b1;
                end else begin
                    s1_reg   <= btn_raw[gi];
                    s2_reg   <= s1_reg;
                    hist_reg <= s2_reg;
                end
            end
            assign edge_det[gi] = s2_reg & ~hist_reg;
        end
    endgenerate

    logic [1:0]    state_reg, state_next;
    logic [31:0]   cnt_reg, cnt_next;
    logic [3:0]    angle_reg, angle_next;
    logic [1:0]    type_reg, type_next;
    logic [1:0]    ult_reg, ult_next;
    logic [CW-1:0] credit_reg, credit_next;
    logic [15:0]   kill_prev_reg;
    logic          ready_reg;

    logic          fire_ok, rot_en, kill_up, restore, consume;
    logic [CW:0]   credit_sum;

    assign fire_ok = edge_fire & ~over & (shootingtype != 2'd0)
                   & ((shootingtype != 2'd3) | (ult_reg != 2'd0));
    assign rot_en  = ~over & (state_reg != FIRE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        type_next  = type_reg;
        case (state_reg)
            IDLE: begin
                if (fire_ok) begin
                    state_next = FIRE;
                    type_next  = shootingtype;
                end
            end
            FIRE: begin
                state_next = COOLDOWN;
                case (type_reg)
                    2'd1:    cnt_next = 32'(COOLDOWN_T1 - 1);
                    2'd2:    cnt_next = 32'(COOLDOWN_T2 - 1);
                    default: cnt_next = 32'(COOLDOWN_T3 - 1);
                endcase
            end
            COOLDOWN: begin
                if (cnt_reg == 32'd0) state_next = IDLE;
                else                  cnt_next   = cnt_reg - 32'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        angle_next = angle_reg;
        if (rot_en) begin
            if (edge_left && !edge_right)      angle_next = angle_reg - 4'd1;
            else if (edge_right && !edge_left) angle_next = angle_reg + 4'd1;
        end
    end

    // Kill credit counts increases only; a drop (enemy block reset) just resyncs kill_prev.
    always_comb begin
        kill_up     = kill_count > kill_prev_reg;
        credit_sum  = {1'b0, credit_reg} + (CW+1)'(kill_up);
        restore     = credit_sum == (CW+1)'(KILLS_PER_CHARGE);
        credit_next = restore ? '0 : credit_sum[CW-1:0];
        consume     = (state_reg == FIRE) && (type_reg == 2'd3);
        ult_next    = ult_reg;
        if (consume && !restore)
            ult_next = ult_reg - 2'd1;
        else if (restore && !consume && (ult_reg < 2'(ULT_MAX)))
            ult_next = ult_reg + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 32'd0;
            angle_reg     <= 4'd0;
            type_reg      <= 2'd0;
            ult_reg       <= 2'(ULT_MAX);
            credit_reg    <= '0;
            kill_prev_reg <= kill_count;
            ready_reg     <= ~over;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            angle_reg     <= angle_next;
            type_reg      <= type_next;
            ult_reg       <= ult_next;
            credit_reg    <= credit_next;
            kill_prev_reg <= kill_count;
            ready_reg     <= (state_next == IDLE) & ~over;
        end
    end

    assign hit_angle            = angle_reg;
    assign outgoing_projectiles = (state_reg == FIRE);
    assign shot_type            = type_reg;
    assign ult_charges          = ult_reg;
    assign ready                = ready_reg;
endmodule

// File: tb/tb_player_shooter.sv
// Directed bench for player_shooter: expected shots are queued at each press and checked
// against every outgoing pulse; state outputs are checked one step after the clock edge.
module tb_player_shooter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
    logic [1:0]  shootingtype = 2'd0;
    logic        over = 1'b0;
    logic [15:0] kill_count = 16'd0;
    logic [3:0]  hit_angle;
    logic        outgoing_projectiles;
    logic [1:0]  shot_type;
    logic [1:0]  ult_charges;
    logic        ready;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];   // {shot_type, hit_angle}

    player_shooter #(
        .COOLDOWN_T1(4), .COOLDOWN_T2(3), .COOLDOWN_T3(2),
        .ULT_MAX(2), .KILLS_PER_CHARGE(3)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
        .shootingtype(shootingtype), .over(over), .kill_count(kill_count),
        .hit_angle(hit_angle), .outgoing_projectiles(outgoing_projectiles),
        .shot_type(shot_type), .ult_charges(ult_charges), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every pulse must match the oldest queued expectation; a pulse with nothing queued fails.
    always @(negedge clk) begin
        if (reset === 1'b1 && outgoing_projectiles !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL pulse_unexpected: observed type=%0d angle=%0d expected no pulse",
                           shot_type, hit_angle);
                end
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                assert ({shot_type, hit_angle} === e) else begin
                    errors++;
                    $error("FAIL pulse_data: observed %0h expected %0h", {shot_type, hit_angle}, e);
                end
                $display("shot: type=%0d angle=%0d", shot_type, hit_angle);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int which);   // 0 left, 1 right, 2 fire, 3 left+right
        btn_left  = (which == 0) || (which == 3);
        btn_right = (which == 1) || (which == 3);
        btn_fire  = (which == 2);
        tick();
        btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
        tick(3);
    endtask

    task automatic shoot(input logic [1:0] t);
        exp_q.push_back({t, hit_angle});
        press(2);
    endtask

    task automatic drained(input string tag);
        tick(3);
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 40 && ready !== 1'b1; i++) tick();
        chk(tag, ready, 1);
    endtask

    initial begin
        // 1: fire held through reset produces no shot
        shootingtype = 2'd1;
        btn_fire = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(6);
        btn_fire = 1'b0;
        tick(3);
        chk("rst_angle", hit_angle, 0);
        chk("rst_ult", ult_charges, 2);
        chk("rst_ready", ready, 1);
        chk("rst_type", shot_type, 0);
        chk("rst_held_fire", exp_q.size(), 0);

        // 2: rotation with wrap and simultaneous presses
        repeat (3) press(0);
        chk("rot_left3", hit_angle, 13);
        repeat (4) press(1);
        chk("rot_right4", hit_angle, 1);
        press(3);
        chk("rot_both", hit_angle, 1);

        // 3: type-1 shot, press during cooldown dropped, then fire again
        btn_fire = 1'b1;
        exp_q.push_back({2'd1, hit_angle});
        tick();
        btn_fire = 1'b0;
        tick(2);                       // FIRE cycle now visible
        chk("t1_pulse", outgoing_projectiles, 1);
        tick();
        chk("t1_cool_ready", ready, 0);
        chk("t1_type_hold", shot_type, 1);
        press(2);                      // lands inside cooldown
        tick(2);
        chk("t1_dropped", exp_q.size(), 0);
        wait_ready("t1_ready");
        shoot(2'd1);
        drained("t1_second");

        // 4: ultimate consumption and kill recharge
        shootingtype = 2'd3;
        wait_ready("u_ready0");
        shoot(2'd3);
        wait_ready("u_ready1");
        chk("u_ult1", ult_charges, 1);
        shoot(2'd3);
        wait_ready("u_ready2");
        chk("u_ult0", ult_charges, 0);
        press(2);
        drained("u_empty_reject");
        chk("u_ult0_hold", ult_charges, 0);
        for (int k = 1; k <= 3; k++) begin
            kill_count = 16'(k);
            tick();
        end
        tick();
        chk("u_recharge", ult_charges, 1);
        kill_count = 16'd0;
        tick(2);
        chk("u_drop", ult_charges, 1);

        // 5: game over blocks fire and rotation; type 0 is safe
        shootingtype = 2'd1;
        over = 1'b1;
        tick(2);
        chk("over_ready", ready, 0);
        press(2);
        press(0);
        drained("over_fire");
        chk("over_angle", hit_angle, 1);
        over = 1'b0;
        shootingtype = 2'd0;
        wait_ready("safe_ready");
        press(2);
        drained("safe_fire");

        // 6: reset in the middle of cooldown
        shootingtype = 2'd3;
        exp_q.push_back({2'd3, hit_angle});
        btn_fire = 1'b1;
        tick();
        btn_fire = 1'b0;
        tick(3);
        chk("mid_ready0", ready, 0);
        reset = 1'b0;
        tick();
        chk("mid_pulse", outgoing_projectiles, 0);
        chk("mid_ready", ready, 1);
        chk("mid_ult", ult_charges, 2);
        chk("mid_angle", hit_angle, 0);
        reset = 1'b1;
        shootingtype = 2'd2;
        tick();
        shoot(2'd2);
        drained("post_reset_shot");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
